// File: rtl/mod5_sequence_monitor.sv
// Checks that a mod-5 counter state advances 0->1->2->3->4->0 one step per clock,
// decodes it to a one-hot phase, counts rollovers and latches the first fault cause.
module mod5_sequence_monitor #(
  parameter int WRAP_MOD = 12,
  parameter int WRAP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        q_in,
  input  logic              clr_err,
  output logic [4:0]        phase,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              carry_out,
  output logic              seq_err,
  output logic [1:0]        err_code,
  output logic              armed
);

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_STEP  = 2'b01,
    ERR_RANGE = 2'b10
  } err_t;

  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(WRAP_MOD - 1);

  state_t     state;
  logic [2:0] prev;

  logic       in_range;
  logic [2:0] prev_succ;
  logic       legal_step;
  logic       rollover;
  logic       cnt_last;
  logic [4:0] q_onehot;

  assign in_range   = (q_in <= 3'd4);
  assign prev_succ  = (prev == 3'd4) ? 3'd0 : prev + 3'd1;
  assign legal_step = (q_in == prev_succ);
  assign rollover   = (prev == 3'd4) && (q_in == 3'd0);
  assign cnt_last   = (wrap_cnt == WRAP_LAST);
  assign q_onehot   = 5'd1 << q_in;

  // reset_n is shared with the upstream counter and already released synchronously
  // by the reset network, so no local synchronizer is added here.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register, including prev, is reset so the block never starts
    // from an undefined history; all state updates use non-blocking assignments.
    if (!reset_n) begin
      state      <= UNARMED;
      prev       <= 3'd0;
      phase      <= 5'd0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      carry_out  <= 1'b0;
      seq_err    <= 1'b0;
      err_code   <= ERR_NONE;
      armed      <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      carry_out  <= 1'b0;
      case (state)
        UNARMED: begin
          if (in_range) begin
            state <= TRACK;
            prev  <= q_in;
            phase <= q_onehot;
            armed <= 1'b1;
          end else begin
            state    <= FAULT;
            seq_err  <= 1'b1;
            err_code <= ERR_RANGE;
            phase    <= 5'd0;
            armed    <= 1'b0;
          end
        end
        TRACK: begin
          // Range violations take precedence over step violations.
          if (!in_range) begin
            state    <= FAULT;
            seq_err  <= 1'b1;
            err_code <= ERR_RANGE;
            phase    <= 5'd0;
            armed    <= 1'b0;
          end else if (legal_step) begin
            prev  <= q_in;
            phase <= q_onehot;
            if (rollover) begin
              wrap_pulse <= 1'b1;
              if (cnt_last) begin
                wrap_cnt  <= '0;
                carry_out <= 1'b1;
              end else begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
              end
            end
          end else begin
            state    <= FAULT;
            seq_err  <= 1'b1;
            err_code <= ERR_STEP;
            phase    <= 5'd0;
            armed    <= 1'b0;
          end
        end
        FAULT: begin
          // err_code keeps the first cause; only a clear leaves this state.
          if (clr_err) begin
            state    <= UNARMED;
            seq_err  <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        default: state <= UNARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_sequence_monitor.sv
// Scoreboard bench for mod5_sequence_monitor: a rollover-counting reference model
// queues the expected outputs per sample; a monitor compares one clock later.
module tb_mod5_sequence_monitor;

  localparam int WRAP_MOD = 12;
  localparam int WRAP_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        q_in;
  logic              clr_err;
  logic [4:0]        phase;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              carry_out;
  logic              seq_err;
  logic [1:0]        err_code;
  logic              armed;

  mod5_sequence_monitor #(.WRAP_MOD(WRAP_MOD), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .q_in       (q_in),
    .clr_err    (clr_err),
    .phase      (phase),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .carry_out  (carry_out),
    .seq_err    (seq_err),
    .err_code   (err_code),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        phase;
    logic              wp;
    logic [WRAP_W-1:0] wc;
    logic              co;
    logic              se;
    logic [1:0]        ec;
    logic              ar;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   carry_seen = 0;
  int   wrap_seen  = 0;

  // Reference model: tracking flag, last legal value, total rollovers seen.
  bit   m_armed, m_fault, m_wp, m_co;
  int   m_last, m_rolls;
  logic [1:0] m_err;
  int   cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_armed = 0; m_fault = 0; m_wp = 0; m_co = 0;
    m_last = 0; m_rolls = 0; m_err = 2'b00;
  endfunction

  function automatic void model_step(input int q, input bit clr);
    m_wp = 0;
    m_co = 0;
    if (m_fault) begin
      if (clr) begin
        m_fault = 0;
        m_err   = 2'b00;
      end
    end else if (q > 4) begin
      m_fault = 1; m_armed = 0; m_err = 2'b10;
    end else if (!m_armed) begin
      m_armed = 1; m_last = q;
    end else if (q == (m_last + 1) % 5) begin
      if (m_last == 4) begin
        m_rolls++;
        m_wp = 1;
        m_co = (m_rolls % WRAP_MOD == 0);
      end
      m_last = q;
    end else begin
      m_fault = 1; m_armed = 0; m_err = 2'b01;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.phase = m_armed ? 5'(1 << m_last) : 5'd0;
    e.wp    = m_wp;
    e.wc    = WRAP_W'(m_rolls % WRAP_MOD);
    e.co    = m_co;
    e.se    = m_fault;
    e.ec    = m_err;
    e.ar    = m_armed;
    return e;
  endfunction

  task automatic apply(input logic [2:0] q, input logic clr);
    q_in    = q;
    clr_err = clr;
    model_step(int'(q), clr);
    exp_q.push_back(model_out());
  endtask

  task automatic cycle(input logic [2:0] q, input logic clr);
    @(negedge clk);
    apply(q, clr);
  endtask

  task automatic legal(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(3'(cnt), 1'b0);
      cnt = (cnt + 1) % 5;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},    32'(phase),      32'd0);
    check({tag, "_wrap"},     32'(wrap_pulse), 32'd0);
    check({tag, "_wrap_cnt"}, 32'(wrap_cnt),   32'd0);
    check({tag, "_carry"},    32'(carry_out),  32'd0);
    check({tag, "_seq_err"},  32'(seq_err),    32'd0);
    check({tag, "_err_code"}, 32'(err_code),   32'd0);
    check({tag, "_armed"},    32'(armed),      32'd0);
  endtask

  // Monitor: outputs are sampled 1 time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("phase",      32'(phase),      32'(e.phase));
        check("wrap_pulse", 32'(wrap_pulse), 32'(e.wp));
        check("wrap_cnt",   32'(wrap_cnt),   32'(e.wc));
        check("carry_out",  32'(carry_out),  32'(e.co));
        check("seq_err",    32'(seq_err),    32'(e.se));
        check("err_code",   32'(err_code),   32'(e.ec));
        check("armed",      32'(armed),      32'(e.ar));
        check("carry_subset", 32'(carry_out & ~wrap_pulse), 32'd0);
        if (carry_out) carry_seen++;
        if (wrap_pulse) wrap_seen++;
      end
    end
  end

  initial begin
    logic [2:0] q;
    logic       clr;
    reset_n = 1'b0;
    q_in    = 3'd0;
    clr_err = 1'b0;
    model_reset();
    cnt = 0;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");

    // Release with the counter at 0, then 60 legal rollovers.
    @(negedge clk);
    reset_n = 1'b1;
    apply(3'd0, 1'b0);
    cnt = 1;
    legal(300);
    @(posedge clk);
    #2;
    check("carry_count_60", 32'(carry_seen), 32'd5);
    check("wrap_count_60",  32'(wrap_seen),  32'd60);

    // Seven more rollovers, step to 2, hold 2, extra bad value, clear, resume.
    legal(35 + 2);
    cycle(3'd2, 1'b0);
    cycle(3'd6, 1'b0);
    cycle(3'd0, 1'b0);
    cycle(3'd3, 1'b1);
    cnt = 3;
    legal(3);

    // Out-of-range fault followed by a would-be step fault; clear; re-arm on 1.
    legal(2);
    cycle(3'd6, 1'b0);
    cycle(3'd1, 1'b0);
    cycle(3'd0, 1'b1);
    cycle(3'd1, 1'b0);
    cnt = 2;
    legal(4);

    // Fresh run to wrap_cnt=5, phase=01000, then asynchronous reset mid-count.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(3'd0, 1'b0);
    cnt = 1;
    legal(28);
    @(posedge clk);
    #2;
    check("pre_reset_wrap_cnt", 32'(wrap_cnt), 32'd5);
    check("pre_reset_phase",    32'(phase),    32'b01000);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(3'd0, 1'b0);
    cnt = 1;
    legal(12);

    // Randomized counting with occasional corrupted samples and clear pulses.
    for (int i = 0; i < 600; i++) begin
      q   = ($urandom_range(0, 99) < 6) ? 3'($urandom_range(0, 7)) : 3'(cnt);
      clr = ($urandom_range(0, 9) == 0);
      cycle(q, clr);
      if (q <= 3'd4) cnt = (int'(q) + 1) % 5;
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
